sap1_loader: RTL

SAP1_LOADER -- requirements
Module: sap1_loader

---
 rtl/sap1_loader_if.sv | 23 ++
 rtl/sap1_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sap1_loader_if.sv
// Host-to-loader byte stream plus the loader's program-memory and CPU-control outputs.
// The loader side uses the slave modport; the host/environment side uses master.
interface sap1_loader_if;
   logic [7:0] DIN;
   logic       DIN_VALID;
   logic       DIN_READY;
   logic       MEM_WE;
   logic [3:0] MEM_ADDR;
   logic [7:0] MEM_DATA;
   logic       CPU_RST;
   logic       LOAD_DONE;
   logic       LOAD_ERR;

   modport master (
      output DIN, DIN_VALID,
      input  DIN_READY, MEM_WE, MEM_ADDR, MEM_DATA, CPU_RST, LOAD_DONE, LOAD_ERR
   );

   modport slave (
      input  DIN, DIN_VALID,
      output DIN_READY, MEM_WE, MEM_ADDR, MEM_DATA, CPU_RST, LOAD_DONE, LOAD_ERR
   );
endinterface

// File: rtl/sap1_loader.sv
// SAP-1 program loader: parses frames of the form A5, count, N data bytes
// (N = count[3:0]+1) and writes the data bytes into the 16x8 program memory,
// holding the SAP-1 core in reset until the program is complete.
// Optional feature macro: SAP1_LOADER_CHECKSUM_EN adds a trailing checksum byte;
// the frame is accepted only if count + data + checksum sums to 0 mod 256.
module sap1_loader (
   input  logic           CLK,
   input  logic           RST,
   sap1_loader_if.slave   bus
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef SAP1_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, RUN, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, COUNT, DATA, RUN, ERROR} state_t;
`endif

   state_t     state_reg, state_next;
   logic [3:0] addr_reg, addr_next;
   logic [3:0] last_reg, last_next;       // index of the final data byte (N-1)
   logic       mem_we_reg, mem_we_next;
   logic [7:0] mem_data_reg, mem_data_next;
`ifdef SAP1_LOADER_CHECKSUM_EN
   logic [7:0] sum_reg, sum_next;
   logic [7:0] sum_check;
`endif

   logic din_ready;
   logic xfer;

   // The write cycle blocks the stream, so a data byte can never overlap its own write.
   assign din_ready = ~mem_we_reg & ~RST;
   assign xfer      = bus.DIN_VALID & din_ready;

`ifdef SAP1_LOADER_CHECKSUM_EN
   assign sum_check = sum_reg + bus.DIN;
`endif

   // State and datapath registers; reset aborts any frame and kills a pending write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         addr_reg     <= 4'd0;
         last_reg     <= 4'd0;
         mem_we_reg   <= 1'b0;
         mem_data_reg <= 8'd0;
`ifdef SAP1_LOADER_CHECKSUM_EN
         sum_reg      <= 8'd0;
`endif
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         last_reg     <= last_next;
         mem_we_reg   <= mem_we_next;
         mem_data_reg <= mem_data_next;
`ifdef SAP1_LOADER_CHECKSUM_EN
         sum_reg      <= sum_next;
`endif
      end
   end

   // Frame parser: next state, address advance, write strobe and running sum.
   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      last_next     = last_reg;
      mem_we_next   = 1'b0;
      mem_data_next = mem_data_reg;
`ifdef SAP1_LOADER_CHECKSUM_EN
      sum_next      = sum_reg;
`endif
      case (state_reg)
         IDLE, RUN, ERROR: begin
            if (xfer && (bus.DIN == SYNC_BYTE)) begin
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (xfer) begin
               last_next  = bus.DIN[3:0];
               addr_next  = 4'd0;
               state_next = DATA;
`ifdef SAP1_LOADER_CHECKSUM_EN
               sum_next   = bus.DIN;
`endif
            end
         end
         DATA: begin
            if (mem_we_reg) begin
               // Leave the state only once the last write strobe has been issued,
               // so the core is never released while memory is still being written.
               if (addr_reg == last_reg) begin
`ifdef SAP1_LOADER_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = RUN;
`endif
               end else begin
                  addr_next = addr_reg + 4'd1;
               end
            end else if (xfer) begin
               mem_we_next   = 1'b1;
               mem_data_next = bus.DIN;
`ifdef SAP1_LOADER_CHECKSUM_EN
               sum_next      = sum_reg + bus.DIN;
`endif
            end
         end
`ifdef SAP1_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) begin
               state_next = (sum_check == 8'd0) ? RUN : ERROR;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.DIN_READY = din_ready;
   assign bus.MEM_WE    = mem_we_reg;
   assign bus.MEM_ADDR  = addr_reg;
   assign bus.MEM_DATA  = mem_data_reg;
   assign bus.CPU_RST   = (state_reg != RUN);
   assign bus.LOAD_DONE = (state_reg == RUN);
`ifdef SAP1_LOADER_CHECKSUM_EN
   assign bus.LOAD_ERR  = (state_reg == ERROR);
`else
   assign bus.LOAD_ERR  = 1'b0;
`endif

endmodule
